// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: shared width limits and binary/Gray conversion helpers
package gray_counter_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic {
        CONV_B2G = 1'b0,
        CONV_G2B = 1'b1
    } conv_mode_e;

    // Helpers work at the widest legal width; callers zero-extend and truncate.
    function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
        logic [WIDTH_MAX-1:0] b;
        b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
        for (int i = WIDTH_MAX - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_conv.sv
// gray_conv: combinational binary<->Gray converter selected by MODE
module gray_conv
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // MODE high treats D as Gray and returns binary, low does the reverse
    always_comb
        Q = (MODE == CONV_G2B) ? WIDTH'(gray2bin(32'(D))) : WIDTH'(bin2gray(32'(D)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with loadable value, registered Gray, binary, wrap and toggle-mask outputs
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic             LD_GRAY,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] B,
    output logic             WRAP,
    output logic [WIDTH-1:0] CHG
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("gray_counter: WIDTH out of range");
    end

    logic             conv_mode;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] ld_bin;
    logic [WIDTH-1:0] ld_gray;
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // One converter serves both load formats: it produces whichever form D lacks
    assign conv_mode = LD_GRAY ? CONV_G2B : CONV_B2G;

    gray_conv #(.WIDTH(WIDTH)) u_conv (
        .MODE (conv_mode),
        .D    (D),
        .Q    (conv)
    );

    // Next-state selection: load beats step; Gray is derived from the next binary value
    always_comb begin
        ld_bin   = LD_GRAY ? conv : D;
        ld_gray  = LD_GRAY ? D : conv;
        step_bin = UP ? B + 1'b1 : B - 1'b1;
        bin_nxt  = LD ? ld_bin : EN ? step_bin : B;
        gray_nxt = LD ? ld_gray : EN ? WIDTH'(bin2gray(32'(step_bin))) : G;
        wrap_nxt = !LD && EN && (UP ? &B : ~|B);
    end

    // Binary state and registered Gray/status outputs; reset overrides everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            B    <= '0;
            G    <= '0;
            WRAP <= 1'b0;
            CHG  <= '0;
        end else begin
            B    <= bin_nxt;
            G    <= gray_nxt;
            WRAP <= wrap_nxt;
            CHG  <= gray_nxt ^ G;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: scoreboard bench, directed WIDTH=4 vectors plus a WIDTH=8 model-checked random run
module tb_gray_counter;

    typedef struct {
        string    name;
        logic [3:0] g, b, c;
        logic     w;
    } exp4_t;

    typedef struct {
        logic [7:0] g, b, c;
        logic     w;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst4 = 1'b1, en4 = 1'b0, up4 = 1'b0, ld4 = 1'b0, lg4 = 1'b0;
    logic [3:0] d4 = '0;
    logic [3:0] g4, b4, c4;
    logic       w4;
    logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b0, ld8 = 1'b0, lg8 = 1'b0;
    logic [7:0] d8 = '0;
    logic [7:0] g8, b8, c8;
    logic       w8;

    exp4_t q4[$];
    exp8_t q8[$];
    int    applied = 0;
    int    miscompares = 0;

    logic [7:0] mb = '0, mg = '0;

    logic [3:0] gt [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_counter #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST(rst4), .EN(en4), .UP(up4), .LD(ld4), .LD_GRAY(lg4), .D(d4),
        .G(g4), .B(b4), .WRAP(w4), .CHG(c4)
    );

    gray_counter #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst8), .EN(en8), .UP(up8), .LD(ld8), .LD_GRAY(lg8), .D(d8),
        .G(g8), .B(b8), .WRAP(w8), .CHG(c8)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: outputs settle after each rising edge, compare at the falling edge
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            exp4_t e;
            e = q4.pop_front();
            applied++;
            if ({g4, b4, w4, c4} !== {e.g, e.b, e.w, e.c}) begin
                miscompares++;
                $display("FAIL %s: got G=%b B=%b WRAP=%b CHG=%b, want G=%b B=%b WRAP=%b CHG=%b",
                         e.name, g4, b4, w4, c4, e.g, e.b, e.w, e.c);
            end
        end
        if (q8.size() > 0) begin
            exp8_t e;
            e = q8.pop_front();
            applied++;
            if ({g8, b8, w8, c8} !== {e.g, e.b, e.w, e.c}) begin
                miscompares++;
                $display("FAIL w8_random: got G=%h B=%h WRAP=%b CHG=%h, want G=%h B=%h WRAP=%b CHG=%h",
                         g8, b8, w8, c8, e.g, e.b, e.w, e.c);
            end
        end
    end

    task automatic vec(input string n, input logic rst, en, up, ld, lg, input logic [3:0] d,
                       input logic [3:0] eg, eb, input logic ew, input logic [3:0] ec);
        exp4_t e;
        rst4 = rst; en4 = en; up4 = up; ld4 = ld; lg4 = lg; d4 = d;
        e.name = n; e.g = eg; e.b = eb; e.w = ew; e.c = ec;
        @(posedge clk);
        q4.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] r = '0;
        for (int s = 0; s < 8; s++) r ^= g >> s;
        return r;
    endfunction

    task automatic vec8(input logic rst, en, up, ld, lg, input logic [7:0] d);
        exp8_t e;
        logic [7:0] nb;
        logic       nw;
        rst8 = rst; en8 = en; up8 = up; ld8 = ld; lg8 = lg; d8 = d;
        nw = 1'b0;
        if (rst) nb = '0;
        else if (ld) nb = lg ? ref_g2b(d) : d;
        else if (en) begin
            nw = up ? (mb == 8'hFF) : (mb == 8'h00);
            nb = up ? mb + 8'd1 : mb - 8'd1;
        end else nb = mb;
        e.b = nb;
        e.g = nb ^ (nb >> 1);
        e.w = nw;
        e.c = rst ? 8'h00 : e.g ^ mg;
        mb = nb;
        mg = e.g;
        @(posedge clk);
        q8.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        vec("reset_over_ld_en", 1, 1, 1, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
        for (int k = 1; k <= 16; k++)
            vec("up_count", 0, 1, 1, 0, 0, 4'b0000, gt[k % 16], 4'(k), k == 16, gt[k % 16] ^ gt[k - 1]);
        vec("down_wrap",        0, 1, 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 1, 4'b1000);
        vec("idle",             0, 0, 0, 0, 0, 4'b0101, 4'b1000, 4'b1111, 0, 4'b0000);
        vec("load_gray",        0, 0, 0, 1, 1, 4'b1101, 4'b1101, 4'b1001, 0, 4'b0101);
        vec("load_bin",         0, 0, 0, 1, 0, 4'b1010, 4'b1111, 4'b1010, 0, 4'b0010);
        vec("load_0011",        0, 0, 0, 1, 0, 4'b0011, 4'b0010, 4'b0011, 0, 4'b1101);
        vec("ld_beats_en",      0, 1, 1, 1, 0, 4'b0101, 4'b0111, 4'b0101, 0, 4'b0101);
        vec("ld_same_value",    0, 1, 1, 1, 0, 4'b0101, 4'b0111, 4'b0101, 0, 4'b0000);
        vec("ld_all_ones",      0, 1, 1, 1, 0, 4'b1111, 4'b1000, 4'b1111, 0, 4'b1111);
        vec("ld_zero_no_wrap",  0, 1, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b1000);
        vec("down_ignore_lg",   0, 1, 0, 0, 1, 4'b1010, 4'b1000, 4'b1111, 1, 4'b1000);
        vec("up_wrap",          0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b1000);
        vec("load_0110",        0, 0, 1, 1, 0, 4'b0110, 4'b0101, 4'b0110, 0, 4'b0101);
        vec("reset_mid_count",  1, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
        vec("resume_from_zero", 0, 1, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001, 0, 4'b0001);
        vec("idle_after_resume",0, 0, 0, 0, 1, 4'b1111, 4'b0001, 4'b0001, 0, 4'b0000);
        vec8(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 400; i++)
            vec8($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        repeat (2) @(negedge clk);
        if (q4.size() != 0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q4.size(), q8.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and code width in bits; legal range 2..32.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 EN  input  1  count enable; one step per cycle while high.
REQ-005 UP  input  1  direction; 1 = increment, 0 = decrement, sampled with EN.
REQ-006 LD  input  1  load strobe; loads D into the counter.
REQ-007 LD_GRAY  input  1  load format; 1 = D is Gray code, 0 = D is plain binary.
REQ-008 D  input  WIDTH  load value.
REQ-009 G  output  WIDTH  registered count, Gray code.
REQ-010 B  output  WIDTH  registered count, binary; always the binary equivalent of G.
REQ-011 WRAP  output  1  registered one-cycle pulse marking a count wrap-around.
REQ-012 CHG  output  WIDTH  registered mask of G bits that toggled on the last update.

Function
REQ-013 Priority per cycle SHALL be RST > LD > EN; UP and LD_GRAY are ignored when their strobe is low.
REQ-014 LD with LD_GRAY=0 SHALL set B=D and G=D^(D>>1) on the next edge.
REQ-015 LD with LD_GRAY=1 SHALL set G=D and B=Gray-to-binary(D) on the next edge. Gray-to-binary is B[MSB]=D[MSB] and B[i]=B[i+1]^D[i].
REQ-016 EN=1 with LD=0 SHALL step B by +1 (UP=1) or -1 (UP=0), modulo 2^WIDTH. G follows as the Gray code of the new B.
REQ-017 Latency: every output SHALL reflect the operation one clock after the controlling inputs are sampled; there are no combinational input-to-output paths.
REQ-018 A counting step SHALL change exactly one bit of G, including across wrap.
REQ-019 WRAP SHALL be 1 for one cycle after an up-step from all-ones to zero, or a down-step from zero to all-ones.
REQ-020 WRAP SHALL be 0 after a load, after an idle cycle and after reset, even if the loaded value is zero or all-ones.
REQ-021 CHG SHALL equal G_new^G_old for the cycle's update, and SHALL be all-zero on idle cycles (EN=0, LD=0).
REQ-022 CHG SHALL be one-hot after every counting step; after a load it may have several bits set.
REQ-023 A load of a value equal to the current count SHALL give CHG=0 and WRAP=0.
REQ-024 LD and EN asserted together SHALL perform the load only; no step is applied that cycle.

Reset
REQ-025 RST=1 at a rising edge SHALL force G=0, B=0, WRAP=0 and CHG=0, whatever LD and EN are doing.
REQ-026 Reset asserted mid-count SHALL abandon the step or load in progress.
REQ-027 Counting SHALL resume from zero on the first edge with RST=0 and EN=1.

Structure
REQ-028 A shared package SHALL hold the WIDTH default, the legal WIDTH bounds, and the bin-to-gray and gray-to-bin conversion functions.
REQ-029 A combinational sub-module gray_conv (parameter WIDTH, port MODE selecting bin-to-gray or gray-to-bin) SHALL normalise the load value D.
REQ-030 The state register SHALL hold binary only. G SHALL be registered separately from the next-state binary value, not derived combinationally at the output.

Verification
REQ-031 Reset then EN=1, UP=1 for 16 cycles, WIDTH=4:
- G steps 0000, 0001, 0011, 0010, 0110 ... 1000, then 0000.
- The final step shows WRAP=1 and CHG=1000.
- Every step shows a one-hot CHG.
REQ-032 From zero, one down-step gives B=1111, G=1000, WRAP=1, CHG=1000.
REQ-033 Loads, WIDTH=4:
- LD=1, LD_GRAY=1, D=1101 gives G=1101, B=1001, WRAP=0.
- LD=1, LD_GRAY=0, D=1010 gives B=1010, G=1111.
REQ-034 Simultaneous events, starting from B=0011:
- LD=1, EN=1, UP=1, D=0101 (binary) gives B=0101, not 0100.
- LD=1, EN=1 with D equal to the current count gives CHG=0.
REQ-035 Reset mid-operation: assert RST while EN=1 at B=0110 gives all outputs zero next cycle, then B=0001 one cycle after RST falls.
REQ-036 At WIDTH=8, a random up/down/load sequence checked against a reference model SHALL hold B=gray2bin(G) every cycle.
